// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the RAM access controller.
// Burst support is enabled by defining RAM_CTRL_BURST_EN.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int LEN_W      = 2;

  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } state_t;

endpackage

// File: rtl/ram_ctrl_addr_gen.sv
// Burst address register with wrap at DEPTH-1 and a remaining-beat
// counter; last is high while the current beat is the final one.
module ram_ctrl_addr_gen
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start,
  input  len_t              len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);

  len_t cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= start;
      cnt  <= len;
    end else if (step) begin
      addr <= (addr == TOP) ? '0 : addr + 1'b1;
      cnt  <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/ram_access_ctrl.sv
// Command-driven RAM access controller: write/read bursts with wrap.
// Define RAM_CTRL_BURST_EN to honour req_len; otherwise single beats.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              done,
  output logic              err,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nxt;
  len_t              len_eff;
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              load, step;
  logic              done_set, err_set;
  logic              capture;
  logic              addr_ok;

`ifdef RAM_CTRL_BURST_EN
  assign len_eff = req_len;
`else
  logic len_unused;
  assign len_unused = ^req_len;
  assign len_eff    = '0;
`endif

  assign addr_ok   = ({1'b0, req_addr} < DEPTH_L);
  assign req_ready = rst_n && (state == IDLE);

  ram_ctrl_addr_gen #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_addr_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .step (step),
    .start(req_addr),
    .len  (len_eff),
    .addr (addr),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rsp_data <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_set;
      err   <= err_set;
      if (capture) rsp_data <= ram_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    capture   = 1'b0;
    wd_ready  = 1'b0;
    rsp_valid = 1'b0;
    ram_en    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (!addr_ok) begin
            err_set = 1'b1;
          end else begin
            load      = 1'b1;
            state_nxt = req_wr ? WRITE : RD_ISSUE;
          end
        end
      end
      WRITE: begin
        wd_ready = 1'b1;
        if (wd_valid) begin
          ram_en    = 1'b1;
          ram_wr    = 1'b1;
          ram_addr  = addr;
          ram_wdata = wd_data;
          if (last) begin
            done_set  = 1'b1;
            state_nxt = IDLE;
          end else begin
            step = 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        ram_en    = 1'b1;
        ram_addr  = addr;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        capture   = 1'b1;
        state_nxt = RD_RESP;
      end
      RD_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          if (last) begin
            done_set  = 1'b1;
            state_nxt = IDLE;
          end else begin
            step      = 1'b1;
            state_nxt = RD_ISSUE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter only moves on a handshake, so this holds while stalled.
  assign rsp_last = (state == RD_RESP) && last;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Randomized bench for ram_access_ctrl against an array-based
// reference of RAM contents and the command cycle schedule.
module tb_ram_access_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
`ifdef RAM_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_len;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0] rsp_data;
  logic          done, err;
  logic          ram_en, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] ram_mem [16];
  logic [DW-1:0] ref_mem [DEPTH];

  int n_vec = 0;
  int n_bad = 0;

  ram_access_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_len  (req_len),
    .wd_valid (wd_valid),
    .wd_ready (wd_ready),
    .wd_data  (wd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_last (rsp_last),
    .done     (done),
    .err      (err),
    .ram_en   (ram_en),
    .ram_wr   (ram_wr),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int beats(input int len);
    return BURST ? len + 1 : 1;
  endfunction

  task automatic idle_chk();
    #1;
    chk("idle_done", done, 0);
    chk("idle_err", err, 0);
    chk("idle_ram_en", ram_en, 0);
    chk("idle_ready", req_ready, 1);
    tick();
  endtask

  task automatic do_write(input int addr, input int len,
                          input logic [31:0] data);
    int a = addr;
    int n = beats(len);
    req_valid = 1; req_wr = 1;
    req_addr = AW'(addr); req_len = 2'(len);
    #1 chk("wr_req_ready", req_ready, 1);
    chk("wr_idle_wd_ready", wd_ready, 0);
    tick();
    req_valid = 0;
    for (int b = 0; b < n; b++) begin
      repeat ($urandom_range(2, 0)) begin
        wd_valid = 0;
        #1 chk("wr_gap_ram_en", ram_en, 0);
        chk("wr_gap_wd_ready", wd_ready, 1);
        tick();
      end
      wd_valid = 1;
      wd_data  = data[8*b +: 8];
      #1 chk("wr_ram_en", ram_en, 1);
      chk("wr_ram_wr", ram_wr, 1);
      chk("wr_ram_addr", ram_addr, a);
      chk("wr_ram_wdata", ram_wdata, data[8*b +: 8]);
      ref_mem[a] = data[8*b +: 8];
      tick();
      wd_valid = 0;
      a = (a + 1) % DEPTH;
    end
    #1 chk("wr_done", done, 1);
    chk("wr_done_idle", req_ready, 1);
    tick();
  endtask

  task automatic do_read(input int addr, input int len,
                         input int smin, input int smax);
    int a = addr;
    int n = beats(len);
    logic [DW-1:0] exp;
    req_valid = 1; req_wr = 0;
    req_addr = AW'(addr); req_len = 2'(len);
    #1 chk("rd_req_ready", req_ready, 1);
    tick();
    req_valid = 0;
    for (int b = 0; b < n; b++) begin
      exp = ref_mem[a];
      #1 chk("rd_issue_en", ram_en, 1);
      chk("rd_issue_wr", ram_wr, 0);
      chk("rd_issue_addr", ram_addr, a);
      chk("rd_issue_valid", rsp_valid, 0);
      tick();
      #1 chk("rd_wait_en", ram_en, 0);
      chk("rd_wait_valid", rsp_valid, 0);
      tick();
      rsp_ready = 0;
      wd_valid  = 1;
      repeat ($urandom_range(smax, smin)) begin
        #1 chk("rd_stall_valid", rsp_valid, 1);
        chk("rd_stall_data", rsp_data, exp);
        chk("rd_stall_last", rsp_last, b == n - 1);
        chk("rd_stall_ram_en", ram_en, 0);
        chk("rd_stall_wd_ready", wd_ready, 0);
        tick();
      end
      wd_valid  = 0;
      rsp_ready = 1;
      #1 chk("rd_valid", rsp_valid, 1);
      chk("rd_data", rsp_data, exp);
      chk("rd_last", rsp_last, b == n - 1);
      tick();
      rsp_ready = 0;
      a = (a + 1) % DEPTH;
    end
    #1 chk("rd_done", done, 1);
    chk("rd_done_idle", req_ready, 1);
    tick();
  endtask

  task automatic do_err(input int addr, input bit wr);
    req_valid = 1; req_wr = wr;
    req_addr = AW'(addr); req_len = 2'($urandom_range(3, 0));
    #1 chk("err_req_ready", req_ready, 1);
    chk("err_acc_ram_en", ram_en, 0);
    tick();
    req_valid = 0;
    #1 chk("err_pulse", err, 1);
    chk("err_ram_en", ram_en, 0);
    chk("err_req_ready_next", req_ready, 1);
    tick();
    #1 chk("err_clear", err, 0);
    tick();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_wd_ready"}, wd_ready, 0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_last, rsp_data}, 0);
    chk({tag, "_pulses"}, {done, err}, 0);
    chk({tag, "_ram"}, {ram_en, ram_wr, ram_addr, ram_wdata}, 0);
  endtask

  task automatic do_reset_mid_write(input int addr, input int len);
    int a = addr;
    int n = beats(len);
    req_valid = 1; req_wr = 1;
    req_addr = AW'(addr); req_len = 2'(len);
    tick();
    req_valid = 0;
    if (n > 1) begin
      wd_valid = 1; wd_data = 8'h77;
      #1 chk("rst_beat1_en", ram_en, 1);
      ref_mem[a] = 8'h77;
      tick();
    end
    wd_valid = 1;
    wd_data  = 8'h5A;
    rst_n    = 0;
    #1 chk_reset_outs("rst_mid");
    tick();
    tick();
    chk_reset_outs("rst_hold");
    wd_valid = 0;
    rst_n    = 1;
    #1 chk("rst_release_ready", req_ready, 1);
    tick();
  endtask

  initial begin
    int a, l;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) ram_mem[i] = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ram_rdata = '0;
    rst_n = 0;
    req_valid = 0; req_wr = 0; req_addr = '0; req_len = '0;
    wd_valid = 0; wd_data = '0; rsp_ready = 0;
    tick();
    tick();
    chk_reset_outs("por");
    rst_n = 1;
    #1 chk("por_release_ready", req_ready, 1);
    tick();

    do_write(1, 0, 32'h0000_00A5);
    do_read(1, 0, 0, 0);
    do_write(3, 2, 32'h0033_2211);
    do_read(3, 2, 0, 2);
    do_read(0, 3, 5, 5);
    do_err(6, 1'b1);
    do_err(4, 1'b0);
    idle_chk();
    do_reset_mid_write(2, 3);
    do_read(2, 1, 0, 1);

    for (int it = 0; it < 150; it++) begin
      a = int'($urandom_range(15, 0));
      l = int'($urandom_range(3, 0));
      d = $urandom;
      if (a >= DEPTH) do_err(a, 1'($urandom));
      else if ($urandom_range(1, 0) == 1) do_write(a, l, d);
      else do_read(a, l, 0, 3);
    end
    idle_chk();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
